car_motion_ctrl: RTL
====================

Name: car_motion_ctrl

Overview:
- Consumer end of the floor-request interface. The request latch captures the switch pattern while closeDoor is high and presents it as a one-hot whichFloor.
- This block drives closeDoor, reads whichFloor, and moves the car one floor at a time toward the target.
- On arrival it opens the door for a dwell period, then requests the next target.
- It sits between the request latch and the floor/door display logic.

Parameters:
- NUM_FLOORS, 6: number of floors; width of the one-hot floor vectors.
- TRAVEL_CYCLES, 8: clock cycles to move one floor (≥1).
- DWELL_CYCLES, 4: clock cycles the door stays open on arrival/reset (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- whichFloor  input  NUM_FLOORS  one-hot target floor from the request latch; bit 0 = floor 1.
- closeDoor  output  1  high = request latch captures switches on the next clk edge.
- currentFloor  output  NUM_FLOORS  one-hot floor the car is at.
- doorOpen  output  1  door open indicator.
- movingUp  output  1  car travelling upward.
- movingDown  output  1  car travelling downward.
- arrived  output  1  one-cycle pulse on arrival at the target.

Behaviour:
- Fixed decisions: one clock (clk); reset is asynchronous and active-high (reset). All state and output registers clear immediately on reset assertion, independent of clk.
- Reset values:
  - state = DOOR_OPEN, dwell and travel counters = 0.
  - currentFloor = 1 (bit 0 set), target register = 1.
  - doorOpen = 1, closeDoor = 0, movingUp = 0, movingDown = 0, arrived = 0.
- All outputs are registered or decoded directly from state registers. There is no combinational path from whichFloor to any output.
- Target valid = exactly one bit of whichFloor set. Floor index comes from a one-hot-to-binary encode. Comparison is on the encoded index.
- State DOOR_OPEN:
  - doorOpen = 1.
  - Dwell counter counts 0..DWELL_CYCLES-1; stays DWELL_CYCLES cycles, then goes to LATCH.
- State LATCH:
  - closeDoor = 1, doorOpen = 0; lasts exactly 1 cycle, then goes to SAMPLE.
  - The request latch updates whichFloor at the edge leaving LATCH.
- State SAMPLE:
  - closeDoor = 1 (held, so the latch keeps tracking the switches).
  - Each cycle whichFloor is compared against currentFloor:
    - valid and higher: capture target, go to MOVE_UP.
    - valid and lower: capture target, go to MOVE_DOWN.
    - equal or invalid (zero or multi-hot): remain in SAMPLE, no movement.
- States MOVE_UP / MOVE_DOWN:
  - closeDoor = 0, doorOpen = 0; movingUp or movingDown = 1 respectively.
  - Travel counter counts 0..TRAVEL_CYCLES-1. At terminal count, currentFloor shifts one position (left for up, right for down) and the counter returns to 0.
  - If the new floor equals the captured target, go to DOOR_OPEN on the same edge, with arrived = 1 for that first DOOR_OPEN cycle only.
- Target is frozen during travel; whichFloor changes while moving are ignored.
- Guard: currentFloor never shifts past floor NUM_FLOORS or below floor 1. If a shift would exceed a bound, force DOOR_OPEN with no shift and no arrived pulse.
- Latency:
  - From leaving DOOR_OPEN to the first movement decision: 2 cycles.
  - Travel of N floors: N*TRAVEL_CYCLES cycles from entering MOVE_*.
- Reset mid-travel or mid-dwell: immediate return to reset values; the car is reported at floor 1 with the door open.

Test Plan:
- Reset held 3 cycles, then released with whichFloor=000001 → doorOpen=1 for 4 cycles, closeDoor=1 for 1 cycle (LATCH), then SAMPLE holds closeDoor=1 indefinitely; currentFloor stays 000001, no motion.
- Switches 000100 via latch (whichFloor=000100 in first SAMPLE cycle) → movingUp=1 next cycle; currentFloor=000010 after 8 cycles, 000100 after 16; on that edge movingUp=0, doorOpen=1, arrived=1 for exactly one cycle.
- From floor 3, whichFloor=100000 → 3 floors up in 24 cycles; a whichFloor change to 000010 during travel is ignored, car still stops at 100000.
- From floor 6, whichFloor=000001 → movingDown=1, 40 cycles to 000001, arrived pulse, doorOpen for 4 cycles, then LATCH.
- In SAMPLE, whichFloor=000000 then 010010 (invalid) → remains in SAMPLE, no moving flags; then 001000 → MOVE toward floor 4.
- Assert reset asynchronously (between clk edges) mid-MOVE_UP at floor 2 → outputs immediately currentFloor=000001, doorOpen=1, movingUp=0, closeDoor=0; normal dwell resumes after release.

Source files
------------

// File: rtl/car_motion_ctrl.sv
// Elevator car motion controller: dwells with the door open, samples a one-hot
// target from the request latch, and steps the car one floor per travel period.
module car_motion_ctrl #(
  parameter int NUM_FLOORS    = 6,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DWELL_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] whichFloor,
  output logic                  closeDoor,
  output logic [NUM_FLOORS-1:0] currentFloor,
  output logic                  doorOpen,
  output logic                  movingUp,
  output logic                  movingDown,
  output logic                  arrived
);

  localparam int IW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);

  typedef enum logic [2:0] {
    DOOR_OPEN,
    LATCH,
    SAMPLE,
    MOVE_UP,
    MOVE_DOWN
  } state_t;

  state_t                  state, state_d;
  logic [DW-1:0]           dwell, dwell_d;
  logic [TW-1:0]           travel, travel_d;
  logic [NUM_FLOORS-1:0]   cur, cur_d;
  logic [NUM_FLOORS-1:0]   tgt, tgt_d;
  logic                    arr, arr_d;
  logic [IW-1:0]           req_idx, cur_idx;
  logic                    req_valid;

  always_comb begin
    req_idx = '0;
    cur_idx = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (whichFloor[i]) req_idx = req_idx | IW'(i);
      if (cur[i])        cur_idx = cur_idx | IW'(i);
    end
  end

  assign req_valid = ($countones(whichFloor) == 1);

  always_comb begin
    state_d  = state;
    dwell_d  = dwell;
    travel_d = travel;
    cur_d    = cur;
    tgt_d    = tgt;
    arr_d    = 1'b0;
    unique case (state)
      DOOR_OPEN: begin
        if (dwell == DWELL_LAST) begin
          dwell_d = '0;
          state_d = LATCH;
        end else begin
          dwell_d = dwell + DW'(1);
        end
      end
      LATCH: state_d = SAMPLE;
      SAMPLE: begin
        if (req_valid && (req_idx > cur_idx)) begin
          tgt_d   = whichFloor;
          state_d = MOVE_UP;
        end else if (req_valid && (req_idx < cur_idx)) begin
          tgt_d   = whichFloor;
          state_d = MOVE_DOWN;
        end
      end
      MOVE_UP: begin
        if (travel == TRAVEL_LAST) begin
          travel_d = '0;
          // Bound hit: stop and open without moving or signalling arrival
          if (cur[NUM_FLOORS-1]) begin
            state_d = DOOR_OPEN;
          end else begin
            cur_d = cur << 1;
            if ((cur << 1) == tgt) begin
              state_d = DOOR_OPEN;
              arr_d   = 1'b1;
            end
          end
        end else begin
          travel_d = travel + TW'(1);
        end
      end
      MOVE_DOWN: begin
        if (travel == TRAVEL_LAST) begin
          travel_d = '0;
          if (cur[0]) begin
            state_d = DOOR_OPEN;
          end else begin
            cur_d = cur >> 1;
            if ((cur >> 1) == tgt) begin
              state_d = DOOR_OPEN;
              arr_d   = 1'b1;
            end
          end
        end else begin
          travel_d = travel + TW'(1);
        end
      end
      default: state_d = DOOR_OPEN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= DOOR_OPEN;
      dwell  <= '0;
      travel <= '0;
      cur    <= NUM_FLOORS'(1);
      tgt    <= NUM_FLOORS'(1);
      arr    <= 1'b0;
    end else begin
      state  <= state_d;
      dwell  <= dwell_d;
      travel <= travel_d;
      cur    <= cur_d;
      tgt    <= tgt_d;
      arr    <= arr_d;
    end
  end

  assign currentFloor = cur;
  assign arrived      = arr;
  assign doorOpen     = (state == DOOR_OPEN);
  assign closeDoor    = (state == LATCH) || (state == SAMPLE);
  assign movingUp     = (state == MOVE_UP);
  assign movingDown   = (state == MOVE_DOWN);

endmodule
